phase_osc_gen: RTL and testbench

Phase-controlled oscillator that produces a neuron's output oscillation from a stored phase value. It is the transmit end of the phase link: the phase-difference measurement path recovers a phase from oscillation edges, and this block turns a phase word back into a square wave offset from a free-running reference period. Phase updates are double-buffered and take effect only at a reference period boundary, so the output never glitches in mid-period.

---
 rtl/phase_osc_gen.sv | 82 ++++++++
 tb/tb_phase_osc_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_osc_gen.sv
// Phase-controlled oscillator: turns a phase word into a square wave offset from a free-running
// reference period. Phase loads are double-buffered and applied only at a period boundary.
module phase_osc_gen #(
    parameter int PW  = 4,
    parameter int DIV = 1
) (
    input  logic          sclk,
    input  logic          re_n,
    input  logic          en,
    input  logic          ld,
    input  logic [PW-1:0] phi_in,
    output logic [PW-1:0] phase,
    output logic          busy,
    output logic          nout,
    output logic          nout_rise,
    output logic          ref_sync
);

    localparam int            PCW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PCW-1:0] PC_MAX = PCW'(DIV - 1);

    logic [PCW-1:0] pcnt;
    logic [PW-1:0]  cnt;
    logic [PW-1:0]  pend;
    logic [PW-1:0]  c;
    logic [PW-1:0]  phase_nx;
    logic [PW-1:0]  d;
    logic           tick;
    logic           wrap;
    logic           nout_nx;

    // The output is evaluated against the phase that is in effect after this tick,
    // so a wrap tick already uses the freshly applied phase.
    always_comb begin
        tick     = en && (pcnt == PC_MAX);
        c        = cnt + PW'(1);
        wrap     = tick && (c == '0);
        phase_nx = wrap ? pend : phase;
        d        = c - phase_nx;
        nout_nx  = ~d[PW-1];
    end

    // Load handshake: ld is a one-cycle strobe with no back-pressure. Every edge with ld=1
    // overwrites pend and raises busy; busy falls at the wrap that applies pend, unless a
    // load lands on that same edge, in which case the new value waits for the following wrap.
    always_ff @(posedge sclk or negedge re_n) begin
        if (!re_n) begin
            pcnt      <= '0;
            cnt       <= '1;
            phase     <= '0;
            pend      <= '0;
            busy      <= 1'b0;
            nout      <= 1'b0;
            nout_rise <= 1'b0;
            ref_sync  <= 1'b0;
        end else begin
            if (tick) begin
                pcnt <= '0;
            end else if (en) begin
                pcnt <= pcnt + PCW'(1);
            end

            if (tick) begin
                cnt  <= c;
                nout <= nout_nx;
            end

            phase <= phase_nx;

            if (ld) begin
                pend <= phi_in;
                busy <= 1'b1;
            end else if (wrap) begin
                busy <= 1'b0;
            end

            nout_rise <= tick && nout_nx && !nout;
            ref_sync  <= wrap;
        end
    end

endmodule

// File: tb/tb_phase_osc_gen.sv
// Bench for phase_osc_gen: a DIV=1 and a DIV=3 instance checked every cycle against a tick-count
// model, plus a vector table and directed sequences for the boundary cases.
module tb_phase_osc_gen;

    localparam int PW   = 4;
    localparam int W    = PW + 4;
    localparam int PER  = 1 << PW;
    localparam int HALF = PER / 2;

    logic          sclk = 1'b0;
    logic          re_n = 1'b0;
    logic          en, ld, en3, ld3;
    logic [PW-1:0] phi, phi3;
    logic [PW-1:0] phase1, phase3;
    logic          busy1, nout1, rise1, ref1;
    logic          busy3, nout3, rise3, ref3;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        int en_cnt;
        int ticks;
        int pend;
        int phase;
        bit busy;
        bit nout;
        bit rise;
        bit refs;
    } model_t;

    typedef struct {
        bit            en;
        bit            ld;
        logic [PW-1:0] phi;
        logic [PW-1:0] phase;
        bit            busy;
        bit            nout;
        bit            rise;
        bit            refs;
    } vec_t;

    model_t m1, m3;
    vec_t   tbl[7];

    phase_osc_gen #(.PW(PW), .DIV(1)) u_dut1 (
        .sclk(sclk), .re_n(re_n), .en(en), .ld(ld), .phi_in(phi),
        .phase(phase1), .busy(busy1), .nout(nout1), .nout_rise(rise1), .ref_sync(ref1)
    );

    phase_osc_gen #(.PW(PW), .DIV(3)) u_dut3 (
        .sclk(sclk), .re_n(re_n), .en(en3), .ld(ld3), .phi_in(phi3),
        .phase(phase3), .busy(busy3), .nout(nout3), .nout_rise(rise3), .ref_sync(ref3)
    );

    // clock / watchdog
    always #5 sclk = ~sclk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // reference model: counts enabled cycles and ticks since reset
    function automatic model_t model_reset();
        model_t m;
        m = '{default: 0};
        return m;
    endfunction

    function automatic model_t model_step(model_t m, bit e, bit l, int p, int div);
        model_t n;
        int     c, d;
        bit     t, nn;
        n      = m;
        n.rise = 0;
        n.refs = 0;
        t      = 0;
        if (e) begin
            n.en_cnt = m.en_cnt + 1;
            t        = (n.en_cnt % div) == 0;
        end
        if (t) begin
            n.ticks = m.ticks + 1;
            c       = (n.ticks - 1) % PER;
            if (c == 0) begin
                n.phase = m.pend;
                n.busy  = 0;
            end
            d      = (c - n.phase + PER) % PER;
            nn     = d < HALF;
            n.rise = nn && !m.nout;
            n.nout = nn;
            n.refs = (c == 0);
        end
        if (l) begin
            n.pend = p;
            n.busy = 1;
        end
        return n;
    endfunction

    function automatic logic [W-1:0] pack(model_t m);
        logic [PW-1:0] p;
        p = PW'(m.phase);
        return {p, m.busy, m.nout, m.rise, m.refs};
    endfunction

    function automatic bit sig(int sel);
        case (sel)
            0:       return ref1;
            1:       return rise1;
            2:       return ref3;
            3:       return rise3;
            4:       return !nout1;
            default: return !nout3;
        endcase
    endfunction

    // scoreboard
    task automatic check_exp(string name, logic [W-1:0] got, logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b required=%b (phase,busy,nout,rise,ref)", name, got, exp);
        end
    endtask

    task automatic check_val(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic check_pop(string name, logic [W-1:0] got);
        logic [W-1:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got=%b required=queued_value", name, got);
        end else begin
            exp = exp_q.pop_front();
            check_exp(name, got, exp);
        end
    endtask

    // driver: one sclk cycle on the DIV=1 instance; DIV=3 inputs come from en3/ld3/phi3
    task automatic cycle(bit e, bit l, int p);
        en  = e;
        ld  = l;
        phi = PW'(p);
        @(posedge sclk);
        m1 = model_step(m1, e, l, p, 1);
        m3 = model_step(m3, en3, ld3, int'(phi3), 3);
        exp_q.push_back(pack(m1));
        exp_q.push_back(pack(m3));
        #1;
        check_pop("dut1", {phase1, busy1, nout1, rise1, ref1});
        check_pop("dut3", {phase3, busy3, nout3, rise3, ref3});
        @(negedge sclk);
    endtask

    task automatic wait_sig(input int sel, input int limit, output int n);
        n = 0;
        do begin
            cycle(1, 0, 0);
            n++;
        end while (!sig(sel) && n < limit);
        if (!sig(sel)) begin
            checks++;
            errors++;
            $display("FAIL wait_sel%0d got=no_event required=event_within_%0d", sel, limit);
        end
    endtask

    initial begin
        int n, n2, n3, pulses;

        tbl[0] = '{1, 0, 0, 0, 0, 1, 1, 1};
        tbl[1] = '{1, 0, 0, 0, 0, 1, 0, 0};
        tbl[2] = '{1, 0, 0, 0, 0, 1, 0, 0};
        tbl[3] = '{1, 1, 5, 0, 1, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 1, 1, 0, 0};
        tbl[5] = '{1, 1, 9, 0, 1, 1, 0, 0};
        tbl[6] = '{1, 0, 0, 0, 1, 1, 0, 0};

        en = 0; ld = 0; phi = '0;
        en3 = 0; ld3 = 0; phi3 = '0;
        m1 = model_reset();
        m3 = model_reset();

        // reset
        #12;
        check_exp("reset_dut1", {phase1, busy1, nout1, rise1, ref1}, '0);
        check_exp("reset_dut3", {phase3, busy3, nout3, rise3, ref3}, '0);
        @(negedge sclk);
        re_n = 1'b1;
        en3  = 1'b1;

        // vector table: first wrap after reset, loads while busy, en hold
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].en, tbl[i].ld, int'(tbl[i].phi));
            check_exp($sformatf("tbl%0d", i), {phase1, busy1, nout1, rise1, ref1},
                      {tbl[i].phase, tbl[i].busy, tbl[i].nout, tbl[i].rise, tbl[i].refs});
        end

        // latest load wins: 9 applied at the wrap, 5 never seen
        wait_sig(0, 40, n);
        check_val("wrap_wait", n, 11);
        check_val("phase_latest", int'(phase1), 9);
        check_val("busy_clear", int'(busy1), 0);
        wait_sig(1, 40, n);
        check_val("lag9", n, 9);
        wait_sig(4, 40, n);
        check_val("high_len", n, HALF);

        // load 5 mid-period, then rise lags ref by 5
        cycle(1, 1, 5);
        check_val("busy_set", int'(busy1), 1);
        wait_sig(0, 40, n);
        check_val("phase5", int'(phase1), 5);
        wait_sig(1, 40, n);
        check_val("lag5", n, 5);

        // load 4, then load 7 on the wrap edge itself
        cycle(1, 1, 4);
        for (int k = 0; k < 40 && (m1.ticks % PER) != 0; k++) cycle(1, 0, 0);
        cycle(1, 1, 7);
        check_val("wrapld_ref", int'(ref1), 1);
        check_val("wrapld_phase", int'(phase1), 4);
        check_val("wrapld_busy", int'(busy1), 1);
        wait_sig(0, 40, n);
        check_val("wrapld_period", n, PER);
        check_val("phase7", int'(phase1), 7);
        check_val("busy_after7", int'(busy1), 0);

        // en=0 hold stretches the period by exactly 10 cycles
        repeat (5) cycle(1, 0, 0);
        pulses = 0;
        en3 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 0);
            pulses += int'(ref1) + int'(rise1) + int'(ref3) + int'(rise3);
        end
        en3 = 1'b1;
        check_val("hold_pulses", pulses, 0);
        wait_sig(0, 60, n);
        check_val("stretched_period", 5 + 10 + n, PER + 10);

        // DIV=3: phase 2 gives a 6-cycle lag, 24/24 duty, 48-cycle period
        ld3 = 1'b1; phi3 = PW'(2);
        cycle(1, 0, 0);
        ld3 = 1'b0;
        wait_sig(2, 120, n);
        check_val("div3_phase", int'(phase3), 2);
        wait_sig(3, 120, n);
        check_val("div3_lag", n, 6);
        wait_sig(5, 120, n2);
        check_val("div3_high", n2, HALF * 3);
        wait_sig(2, 120, n3);
        check_val("div3_period", n + n2 + n3, PER * 3);

        // randomized traffic on both instances
        for (int k = 0; k < 1500; k++) begin
            en3  = ($urandom_range(0, 9) != 0);
            ld3  = ($urandom_range(0, 15) == 0);
            phi3 = PW'($urandom_range(0, PER - 1));
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
                  int'($urandom_range(0, PER - 1)));
        end
        en3 = 1'b1; ld3 = 1'b0;

        // asynchronous reset mid-period discards a pending load
        cycle(1, 1, 3);
        #2;
        re_n = 1'b0;
        #1;
        check_exp("async_rst_dut1", {phase1, busy1, nout1, rise1, ref1}, '0);
        check_exp("async_rst_dut3", {phase3, busy3, nout3, rise3, ref3}, '0);
        m1 = model_reset();
        m3 = model_reset();
        @(negedge sclk);
        re_n = 1'b1;
        cycle(1, 0, 0);
        check_val("post_rst_ref", int'(ref1), 1);
        check_val("post_rst_rise", int'(rise1), 1);
        wait_sig(0, 40, n);
        check_val("post_rst_phase", int'(phase1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
